bubsys_ioctl_loader: RTL
========================

# bubsys_ioctl_loader

Download front-end between the HPS ioctl byte stream and the Bubble System game board. It packs ROM bytes into big-endian 16-bit words and issues them to the SDRAM write port with a req/ack handshake, throttling the HPS through ioctl wait. It also captures the DIP-switch bytes into a register and holds the game board in reset while a ROM load is in progress.

## Interface
Parameters:
- ROM_INDEX, 16'd0, ioctl index carrying the ROM image
- DIP_INDEX, 16'd254, ioctl index carrying DIP-switch bytes
- ADDR_W, 24, SDRAM word-address width
- DIP_BYTES, 3, number of DIP bytes captured (1..4)

Ports:
- i_EMU_MCLK  in  1  system clock (72 MHz)
- i_EMU_INITRST_n  in  1  asynchronous active-low reset
- i_IOCTL_INDEX  in  16  download index
- i_IOCTL_DOWNLOAD  in  1  download active
- i_IOCTL_ADDR  in  27  byte address
- i_IOCTL_DATA  in  8  byte data
- i_IOCTL_WR  in  1  byte strobe, one cycle
- o_IOCTL_WAIT  out  1  stall request to HPS
- o_SDRAM_WR_REQ  out  1  word write request, level
- o_SDRAM_WR_ADDR  out  ADDR_W  word address = byte address[ADDR_W:1]
- o_SDRAM_WR_DATA  out  16  {even byte, odd byte}
- i_SDRAM_WR_ACK  in  1  one-cycle write-accepted pulse
- o_DIPSW  out  8*DIP_BYTES  DIP register, byte n at [8n+7:8n]
- o_ROM_LOADING  out  1  high during ROM load, including final flush
- o_ROM_LOADED  out  1  sticky, at least one ROM load completed

## Operation
- Reset values: WAIT 0, REQ 0, ADDR 0, DATA 0, DIPSW 0, LOADING 0, LOADED 0, FSM IDLE, hold register empty.
- ROM strobes are accepted only when DOWNLOAD=1 and INDEX=ROM_INDEX. DIP strobes are accepted only when DOWNLOAD=1 and INDEX=DIP_INDEX. All other strobes are ignored.
- FSM states: IDLE, HELD, REQ.
- IDLE:
  - Even-address ROM byte: latch it as the high byte and its word address, then go to HELD.
  - Odd-address ROM byte: form {8'h00, byte} and go to REQ.
- HELD:
  - Odd byte at the same word address: form {held, byte} and go to REQ.
  - Even byte, or odd byte at a different word address: form {held, 8'h00} for the held word, go to REQ, and set a replay flag. After the ack, the new byte is processed as if just arrived from IDLE.
  - DOWNLOAD falls: flush {held, 8'h00} through REQ.
- REQ: REQ=1, with ADDR and DATA stable until the cycle in which ACK=1. Next state is IDLE, or the replay handling above.
- WAIT is asserted on the cycle after any strobe that moves the FSM to REQ. It stays high until the cycle after ACK; on replay it stays high through the replayed byte's handling.
- ACK is ignored while REQ=0.
- DIP capture: byte at address a < DIP_BYTES is written to DIPSW[8a+7:8a]; higher addresses are ignored. DIPSW is not cleared by any download; only reset clears it.
- LOADING rises on the cycle after DOWNLOAD=1 with INDEX=ROM_INDEX is first seen. It falls when DOWNLOAD=0 and the FSM is back in IDLE.
- LOADED clears when LOADING rises. It sets when LOADING falls, provided at least one ack was received during that load.
- Reset asserted mid-operation: the pending word is discarded and all outputs return to reset values asynchronously.

## Timing
- All outputs are registered.
- Strobe at cycle t completing a word: REQ, ADDR and DATA are valid at t+1, and WAIT=1 at t+1.
- ACK at cycle k: REQ=0 and WAIT=0 at k+1.
- Minimum word cost is 3 cycles (strobe, REQ, ACK at t+2).
- WAIT is registered, so the HPS must not issue another strobe within 1 cycle of a word-completing strobe. hps_io strobe spacing guarantees this.
- DIP byte visible on DIPSW one cycle after its strobe.
- DOWNLOAD falling edge while in HELD: REQ asserted on the next cycle.

## Test plan
- ROM index 0, bytes 0x12@0, 0x34@1, ACK 2 cycles after REQ -> REQ with ADDR 0, DATA 16'h1234. WAIT high from strobe+1 until ACK+1. LOADED=1 after DOWNLOAD falls.
- Odd-length image, bytes 0xAA@0, 0xBB@1, 0xCC@2, then DOWNLOAD falls -> words 16'hAABB@0 and 16'hCC00@1. LOADING stays high until the second ACK.
- Address skip, 0x11@0 then 0x22@4 -> 16'h1100@0 written, then 0x22 held. WAIT stays high across the replay. DOWNLOAD fall flushes 16'h2200@2.
- DIP index 254, bytes 0x5A@0, 0xC3@2, 0xFF@7 (DIP_BYTES=3) -> DIPSW=24'hC3005A, no SDRAM request, LOADING stays 0.
- Reset driven low while REQ=1, then released -> REQ, WAIT, LOADING and LOADED all 0. A later ACK produces no activity. The next download starts cleanly at IDLE.
- Strobes with INDEX=3, and ACK pulses while idle -> no REQ, no WAIT, DIPSW unchanged.

Source files
------------

// File: rtl/bubsys_ioctl_loader.sv
// bubsys_ioctl_loader
// HPS ioctl download front-end for the Bubble System core. ROM bytes are
// packed big-endian into 16-bit words and written to SDRAM through a
// level request / pulse acknowledge handshake, with ioctl_wait throttling
// the HPS while a word is outstanding. DIP-switch bytes are captured into
// a register, and a loading flag holds the game board in reset during a
// ROM download.
module bubsys_ioctl_loader #(
  parameter logic [15:0] ROM_INDEX = 16'd0,
  parameter logic [15:0] DIP_INDEX = 16'd254,
  parameter int          ADDR_W    = 24,
  parameter int          DIP_BYTES = 3
) (
  input  logic                   i_EMU_MCLK,
  input  logic                   i_EMU_INITRST_n,
  input  logic [15:0]            i_IOCTL_INDEX,
  input  logic                   i_IOCTL_DOWNLOAD,
  input  logic [26:0]            i_IOCTL_ADDR,
  input  logic [7:0]             i_IOCTL_DATA,
  input  logic                   i_IOCTL_WR,
  output logic                   o_IOCTL_WAIT,
  output logic                   o_SDRAM_WR_REQ,
  output logic [ADDR_W-1:0]      o_SDRAM_WR_ADDR,
  output logic [15:0]            o_SDRAM_WR_DATA,
  input  logic                   i_SDRAM_WR_ACK,
  output logic [8*DIP_BYTES-1:0] o_DIPSW,
  output logic                   o_ROM_LOADING,
  output logic                   o_ROM_LOADED
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_REQ  = 2'd2
  } state_e;

  // Packer state
  state_e              state_q;
  logic [7:0]          held_byte_q;
  logic [ADDR_W-1:0]   held_addr_q;

  // A byte that forced out a partial word waits here until the ack
  logic                replay_q;
  logic [7:0]          replay_byte_q;
  logic [ADDR_W:0]     replay_addr_q;

  // SDRAM write port and HPS throttle
  logic                req_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [15:0]         wr_data_q;
  logic                wait_q;

  // Load status
  logic                loading_q;
  logic                loaded_q;
  logic                ack_seen_q;

  // DIP-switch bytes
  logic [7:0]          dip_bytes_q [DIP_BYTES];

  // Qualified strobes
  logic                rom_sel;
  logic                rom_wr;
  logic                dip_wr;
  logic                ack_acc;

  // Byte presented to the IDLE state: a pending replay takes priority
  logic                cur_valid_d;
  logic [7:0]          cur_byte_d;
  logic [ADDR_W:0]     cur_addr_d;

  assign rom_sel = i_IOCTL_DOWNLOAD && (i_IOCTL_INDEX == ROM_INDEX);
  assign rom_wr  = i_IOCTL_WR && rom_sel;
  assign dip_wr  = i_IOCTL_WR && i_IOCTL_DOWNLOAD && (i_IOCTL_INDEX == DIP_INDEX);
  // An ack only means something while a request is actually outstanding
  assign ack_acc = (state_q == ST_REQ) && i_SDRAM_WR_ACK;

  // Select between a freshly strobed byte and one deferred by an address break
  always_comb begin
    cur_valid_d = rom_wr;
    cur_byte_d  = i_IOCTL_DATA;
    cur_addr_d  = i_IOCTL_ADDR[ADDR_W:0];
    if (replay_q) begin
      cur_valid_d = 1'b1;
      cur_byte_d  = replay_byte_q;
      cur_addr_d  = replay_addr_q;
    end
  end

  // Word packer FSM: gathers byte pairs and drives the SDRAM handshake and WAIT
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      state_q       <= ST_IDLE;
      held_byte_q   <= 8'h00;
      held_addr_q   <= '0;
      replay_q      <= 1'b0;
      replay_byte_q <= 8'h00;
      replay_addr_q <= '0;
      req_q         <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= 16'h0000;
      wait_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cur_valid_d) begin
            replay_q <= 1'b0;
            if (!cur_addr_d[0]) begin
              // Even byte opens a word; the HPS may carry on immediately
              held_byte_q <= cur_byte_d;
              held_addr_q <= cur_addr_d[ADDR_W:1];
              wait_q      <= 1'b0;
              state_q     <= ST_HELD;
            end else begin
              // Lone odd byte: its high half was never sent, so write zero
              wr_addr_q <= cur_addr_d[ADDR_W:1];
              wr_data_q <= {8'h00, cur_byte_d};
              req_q     <= 1'b1;
              wait_q    <= 1'b1;
              state_q   <= ST_REQ;
            end
          end
        end

        ST_HELD: begin
          if (rom_wr) begin
            wr_addr_q <= held_addr_q;
            req_q     <= 1'b1;
            wait_q    <= 1'b1;
            state_q   <= ST_REQ;
            if (i_IOCTL_ADDR[0] && (i_IOCTL_ADDR[ADDR_W:1] == held_addr_q)) begin
              wr_data_q <= {held_byte_q, i_IOCTL_DATA};
            end else begin
              // Address break: emit the half word and revisit this byte afterwards
              wr_data_q     <= {held_byte_q, 8'h00};
              replay_q      <= 1'b1;
              replay_byte_q <= i_IOCTL_DATA;
              replay_addr_q <= i_IOCTL_ADDR[ADDR_W:0];
            end
          end else if (!i_IOCTL_DOWNLOAD) begin
            // End of an odd-length image: flush the held byte
            wr_addr_q <= held_addr_q;
            wr_data_q <= {held_byte_q, 8'h00};
            req_q     <= 1'b1;
            state_q   <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (ack_acc) begin
            req_q   <= 1'b0;
            // Keep the HPS stalled while a deferred byte still has to be handled
            wait_q  <= replay_q;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Loading / loaded status: loading spans the whole download plus the final flush
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      loading_q  <= 1'b0;
      loaded_q   <= 1'b0;
      ack_seen_q <= 1'b0;
    end else if (!loading_q) begin
      if (rom_sel) begin
        loading_q  <= 1'b1;
        loaded_q   <= 1'b0;
        ack_seen_q <= 1'b0;
      end
    end else begin
      if (ack_acc) begin
        ack_seen_q <= 1'b1;
      end
      if (!i_IOCTL_DOWNLOAD && (state_q == ST_IDLE) && !replay_q) begin
        loading_q <= 1'b0;
        if (ack_seen_q) begin
          loaded_q <= 1'b1;
        end
      end
    end
  end

  // One capture register per DIP byte; addresses past the last byte fall through
  for (genvar gi = 0; gi < DIP_BYTES; gi++) begin : g_dip
    // Capture DIP byte gi when its address is strobed
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
      if (!i_EMU_INITRST_n) begin
        dip_bytes_q[gi] <= 8'h00;
      end else if (dip_wr && (i_IOCTL_ADDR == 27'(gi))) begin
        dip_bytes_q[gi] <= i_IOCTL_DATA;
      end
    end
    assign o_DIPSW[8*gi +: 8] = dip_bytes_q[gi];
  end

  assign o_IOCTL_WAIT    = wait_q;
  assign o_SDRAM_WR_REQ  = req_q;
  assign o_SDRAM_WR_ADDR = wr_addr_q;
  assign o_SDRAM_WR_DATA = wr_data_q;
  assign o_ROM_LOADING   = loading_q;
  assign o_ROM_LOADED    = loaded_q;

endmodule
